// File: rtl/spi_frame_loader.sv
// Receive-only SPI loader for a ROWS x COLS one-bit frame, double-buffered so the
// scan driver only ever sees complete, correctly sized frames.
module spi_frame_loader #(
    parameter int ROWS        = 16,
    parameter int COLS        = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sck,
    input  logic                      sdi,
    input  logic                      cs_n,
    output logic [ROWS-1:0][COLS-1:0] matrix,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      busy
);
    localparam int TOTAL = ROWS * COLS;
    localparam int CW    = $clog2(TOTAL) + 1;
    localparam int CB    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sck_s, sdi_s, cs_s;
    logic                   sck_q, cs_q;
    logic                   sck_rise, cs_fall, cs_rise, sdi_b;

    state_t                   state;
    logic [CW-1:0]            bitcnt;
    logic [COLS-1:0]          rowreg;
    logic                     ovf;
    logic [ROWS-1:0][COLS-1:0] back;
    logic [RW-1:0]            row;

    // cs_n synchronizer resets low so a reset taken mid-transfer (cs_n still low)
    // cannot manufacture a falling edge and restart reception halfway through a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s <= '0;
            sdi_s <= '0;
            cs_s  <= '0;
            sck_q <= 1'b0;
            cs_q  <= 1'b0;
        end else begin
            sck_s <= {sck_s[SYNC_STAGES-2:0], sck};
            sdi_s <= {sdi_s[SYNC_STAGES-2:0], sdi};
            cs_s  <= {cs_s[SYNC_STAGES-2:0], cs_n};
            sck_q <= sck_s[SYNC_STAGES-1];
            cs_q  <= cs_s[SYNC_STAGES-1];
        end
    end

    assign sck_rise = sck_s[SYNC_STAGES-1] & ~sck_q;
    assign cs_fall  = ~cs_s[SYNC_STAGES-1] & cs_q;
    assign cs_rise  = cs_s[SYNC_STAGES-1] & ~cs_q;
    assign sdi_b    = sdi_s[SYNC_STAGES-1];
    assign row      = bitcnt[CB +: RW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bitcnt     <= '0;
            rowreg     <= '0;
            ovf        <= 1'b0;
            back       <= '0;
            matrix     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        bitcnt <= '0;
                        rowreg <= '0;
                        ovf    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= RECV;
                    end
                end
                RECV: begin
                    // end of frame wins over a coincident sck edge
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end else if (sck_rise) begin
                        if (bitcnt < CW'(TOTAL)) begin
                            rowreg <= {rowreg[COLS-2:0], sdi_b};
                            bitcnt <= bitcnt + CW'(1);
                            if (bitcnt[CB-1:0] == CB'(COLS - 1))
                                back[row] <= {rowreg[COLS-2:0], sdi_b};
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    if (bitcnt == CW'(TOTAL) && !ovf) begin
                        matrix     <= back;
                        frame_done <= 1'b1;
                    end else begin
                        frame_err  <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboarded bench for spi_frame_loader: each frame pushes its expected pulse and
// matrix; a negedge monitor pops and compares whenever frame_done/frame_err fires.
module tb_spi_frame_loader;
    localparam int ROWS = 16;
    localparam int COLS = 32;
    localparam int SS   = 2;

    typedef logic [ROWS-1:0][COLS-1:0] mat_t;
    typedef struct {
        logic done;
        mat_t mat;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, sck = 1'b0, sdi = 1'b0, cs_n = 1'b1;
    mat_t matrix;
    logic frame_done, frame_err, busy;

    int   checks = 0, fails = 0, jit = 0;
    exp_t q[$];
    mat_t model = '0, prev_m;

    spi_frame_loader #(.ROWS(ROWS), .COLS(COLS), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs_n(cs_n),
        .matrix(matrix), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (frame_done || frame_err)) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", frame_done, frame_err);
            end else begin
                e = q.pop_front();
                check("pulse_kind", {frame_done, frame_err}, {e.done, !e.done});
                check("matrix", matrix, e.mat);
            end
        end
        // matrix may only move together with frame_done
        if (!reset && matrix !== prev_m) check("matrix_change_with_done", frame_done, 1'b1);
        prev_m = matrix;
    end

    task automatic spi_bit(input logic b);
        sdi = b;
        #(20 + $urandom_range(0, jit));
        sck = 1'b1;
        #(20 + $urandom_range(0, jit));
        sck = 1'b0;
    endtask

    task automatic send_frame(input mat_t f, input int nbits);
        exp_t e;
        logic b;
        if (nbits == ROWS * COLS) begin
            e.done = 1'b1; e.mat = f; model = f;
        end else begin
            e.done = 1'b0; e.mat = model;
        end
        q.push_back(e);
        cs_n = 1'b0;
        #30;
        for (int i = 0; i < nbits; i++) begin
            if (i < ROWS * COLS) b = f[i / COLS][COLS - 1 - (i % COLS)];
            else b = 1'($urandom);
            spi_bit(b);
            if (i == 0) check("busy_in_frame", busy, 1'b1);
        end
        #30;
        @(posedge clk); #1 cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("latency_early", frame_done | frame_err, 1'b0);
        @(posedge clk);
        #1 check("latency_pulse", frame_done | frame_err, 1'b1);
        @(posedge clk);
        #1 check("busy_after", busy, 1'b0);
        #60;
    endtask

    initial begin : stim
        mat_t f;
        #23;
        check("rst_matrix", matrix, '0);
        check("rst_done", frame_done, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk) reset = 1'b0;
        #50;

        // 1: diagonal frame
        for (int r = 0; r < ROWS; r++) f[r] = 32'h1 << r;
        send_frame(f, 512);

        // 2: all ones, then short frame
        send_frame('1, 512);
        send_frame(f, 300);

        // 3: one extra bit
        send_frame(f, 513);

        // 4: reset mid-frame, then checkerboard
        cs_n = 1'b0;
        #30;
        repeat (200) spi_bit(1'($urandom));
        #7 reset = 1'b1;
        #20;
        check("midrst_matrix", matrix, '0);
        check("midrst_busy", busy, 1'b0);
        model = '0;
        @(negedge clk) reset = 1'b0;
        #20 cs_n = 1'b1;
        #60;
        for (int r = 0; r < ROWS; r++) f[r] = r[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
        send_frame(f, 512);

        // 5: random frames with sck jitter
        jit = 3;
        for (int n = 0; n < 20; n++) begin
            for (int r = 0; r < ROWS; r++) f[r] = $urandom;
            send_frame(f, 512);
        end

        // 6: sck activity with cs_n high
        jit = 0;
        for (int k = 0; k < 10; k++) begin
            spi_bit(1'($urandom));
            check("idle_busy", busy, 1'b0);
        end
        #60;
        check("idle_matrix", matrix, model);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
